// File: rtl/skeleton_ctrl_pkg.sv
// Shared definitions for the skeleton bus master.
//   - command opcodes carried in bits [7:6] of a command byte
//   - acknowledge bytes returned by a CALC command
//   - the control FSM state encoding (also exported on DBG_STATE)
package skeleton_ctrl_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CALC  = 2'b10;
  localparam logic [1:0] OP_HEAD  = 2'b11;

  localparam logic [7:0] ACK_OK  = 8'hA5;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_ADR   = 3'd3,
    ST_RD_SMP   = 3'd4,
    ST_TRG      = 3'd5,
    ST_WAIT_RDY = 3'd6,
    ST_SEND     = 3'd7
  } state_t;

endpackage

// File: rtl/skeleton_resp_serializer.sv
// Response serializer: a 4-byte load/shift buffer that presents its bytes
// MSB first on a valid/ready byte interface.
//
// Handshake: a byte transfers on a rising edge where o_tx_valid && i_tx_rdy.
// While o_tx_valid is high and i_tx_rdy is low, o_tx_data is held stable.
//
// Ports:
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_load          load i_data / i_cnt and start sending (only when idle)
//   i_data [31:0]   response, left-aligned (first byte in [31:24])
//   i_cnt  [2:0]    number of bytes to send, 1..4
//   i_tx_rdy        transmitter accepts the current byte
//   o_tx_data [7:0] current byte (registered)
//   o_tx_valid      current byte valid (registered)
//   o_done          last byte is transferring on this edge
module skeleton_resp_serializer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_cnt,
  input  logic        i_tx_rdy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        w_hs;

  assign w_hs       = r_valid && i_tx_rdy;
  assign o_done     = w_hs && (r_cnt == 3'd1);
  assign o_tx_data  = r_buf[31:24];
  assign o_tx_valid = r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_cnt   <= i_cnt;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_buf <= r_buf << 8;
      r_cnt <= r_cnt - 3'd1;
      if (r_cnt == 3'd1) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/skeleton_bus_master.sv
// Bus master that turns a UART command byte stream into skeleton register
// transactions (operand write, calc trigger + ready wait, result read,
// header read) and returns response bytes to the UART transmitter.
//
// Handshakes: RX and TX byte transfers happen on a rising edge where the
// valid and ready of that link are both high. RX_RDY is only high in IDLE
// and GET_DATA, so extra bytes are back-pressured, never dropped.
//
// Ports:
//   CLK_SYS, RSTN       clock / asynchronous active-low reset
//   RX_DATA/VALID/RDY   command byte input link
//   TX_DATA/VALID/RDY   response byte output link
//   EN, RnW, ADR, DATA_IN, TRGG_START_CALC   skeleton bus outputs
//   DATA_OUT, DATA_HEAD, RDY                 skeleton bus inputs
//   BUSY                high whenever the FSM is not in IDLE
//   DBG_STATE           current FSM state (state_t encoding)
module skeleton_bus_master
  import skeleton_ctrl_pkg::*;
#(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_HEAD = 26,
  parameter int TRG_CYCLES    = 2,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     CLK_SYS,
  input  logic                     RSTN,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  output logic                     RX_RDY,
  output logic [7:0]               TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_RDY,
  output logic                     EN,
  output logic                     RnW,
  output logic [BITWIDTH_ADR-1:0]  ADR,
  output logic [BITWIDTH_SYS-1:0]  DATA_IN,
  input  logic [BITWIDTH_SYS-1:0]  DATA_OUT,
  input  logic [BITWIDTH_HEAD-1:0] DATA_HEAD,
  output logic                     TRGG_START_CALC,
  input  logic                     RDY,
  output logic                     BUSY,
  output logic [STATE_W-1:0]       DBG_STATE
);

  localparam int NBYTES = BITWIDTH_SYS / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int TRG_W  = $clog2(TRG_CYCLES + 1);

  state_t                   r_state, w_next;
  logic [2:0]               r_bcnt;
  logic [TRG_W-1:0]         r_trg_cnt;
  logic [CNT_W-1:0]         r_to_cnt, w_to_cnt_nxt;
  logic                     r_rdy_seen;
  logic                     w_timeout;
  logic                     w_rx_hs;

  logic                     r_en, r_rnw, r_trg, r_rx_rdy, r_busy;
  logic [BITWIDTH_ADR-1:0]  r_adr;
  logic [BITWIDTH_SYS-1:0]  r_data_in;

  logic                     w_ser_load, w_ser_done;
  logic [31:0]              w_ser_data;
  logic [2:0]               w_ser_cnt;
  logic [31:0]              w_rd_aligned;

  assign w_rx_hs      = RX_VALID && r_rx_rdy;
  // Read data left-aligned so the serializer always emits from bit 31 down.
  assign w_rd_aligned = 32'(DATA_OUT) << (32 - BITWIDTH_SYS);
  // Saturating wait counter; the FSM leaves WAIT_RDY before it would wrap.
  assign w_to_cnt_nxt = (r_to_cnt == CNT_W'(TIMEOUT)) ? r_to_cnt : r_to_cnt + CNT_W'(1);
  assign w_timeout    = (w_to_cnt_nxt == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and serializer load
  always_comb begin
    w_next     = r_state;
    w_ser_load = 1'b0;
    w_ser_data = '0;
    w_ser_cnt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_hs) begin
          case (RX_DATA[7:6])
            OP_WRITE: w_next = ST_GET_DATA;
            OP_READ:  w_next = ST_RD_ADR;
            OP_CALC:  w_next = ST_TRG;
            default: begin
              w_next     = ST_SEND;
              w_ser_load = 1'b1;
              w_ser_data = 32'(DATA_HEAD);
              w_ser_cnt  = 3'd4;
            end
          endcase
        end
      end
      ST_GET_DATA: begin
        if (w_rx_hs && (r_bcnt == 3'(NBYTES - 1))) begin
          w_next = ST_WR;
        end
      end
      ST_WR:     w_next = ST_IDLE;
      ST_RD_ADR: w_next = ST_RD_SMP;
      ST_RD_SMP: begin
        w_next     = ST_SEND;
        w_ser_load = 1'b1;
        w_ser_data = w_rd_aligned;
        w_ser_cnt  = 3'(NBYTES);
      end
      ST_TRG: begin
        if (r_trg_cnt == TRG_W'(TRG_CYCLES - 1)) begin
          w_next = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        // RDY seen on the very first sample means the result is already
        // settled; a later RDY gets one extra cycle for the result register.
        if (r_rdy_seen || (RDY && (r_to_cnt == '0))) begin
          w_next     = ST_SEND;
          w_ser_load = 1'b1;
          w_ser_data = {ACK_OK, 24'h0};
          w_ser_cnt  = 3'd1;
        end else if (!RDY && w_timeout) begin
          w_next     = ST_SEND;
          w_ser_load = 1'b1;
          w_ser_data = {ACK_ERR, 24'h0};
          w_ser_cnt  = 3'd1;
        end
      end
      ST_SEND: begin
        if (w_ser_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs (outputs follow the next state so they
  // line up with the state they belong to).
  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      r_en       <= 1'b0;
      r_rnw      <= 1'b1;
      r_trg      <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_busy     <= 1'b0;
      r_adr      <= '0;
      r_data_in  <= '0;
      r_bcnt     <= '0;
      r_trg_cnt  <= '0;
      r_to_cnt   <= '0;
      r_rdy_seen <= 1'b0;
    end else begin
      r_en     <= 1'b1;
      r_rx_rdy <= (w_next == ST_IDLE) || (w_next == ST_GET_DATA);
      r_rnw    <= (w_next != ST_WR);
      r_trg    <= (w_next == ST_TRG);
      r_busy   <= (w_next != ST_IDLE);

      if ((r_state == ST_IDLE) && w_rx_hs) begin
        r_adr <= RX_DATA[BITWIDTH_ADR-1:0];
      end

      if (r_state == ST_IDLE) begin
        r_bcnt <= '0;
      end else if ((r_state == ST_GET_DATA) && w_rx_hs) begin
        r_bcnt    <= r_bcnt + 3'd1;
        r_data_in <= (r_data_in << 8) | BITWIDTH_SYS'(RX_DATA);
      end

      if (r_state == ST_TRG) begin
        r_trg_cnt <= r_trg_cnt + TRG_W'(1);
      end else begin
        r_trg_cnt <= '0;
      end

      if (r_state == ST_WAIT_RDY) begin
        r_to_cnt <= w_to_cnt_nxt;
        if (RDY) begin
          r_rdy_seen <= 1'b1;
        end
      end else begin
        r_to_cnt   <= '0;
        r_rdy_seen <= 1'b0;
      end
    end
  end

  skeleton_resp_serializer u_ser (
    .i_clk      (CLK_SYS),
    .i_rst_n    (RSTN),
    .i_load     (w_ser_load),
    .i_data     (w_ser_data),
    .i_cnt      (w_ser_cnt),
    .i_tx_rdy   (TX_RDY),
    .o_tx_data  (TX_DATA),
    .o_tx_valid (TX_VALID),
    .o_done     (w_ser_done)
  );

  assign EN              = r_en;
  assign RnW             = r_rnw;
  assign ADR             = r_adr;
  assign DATA_IN         = r_data_in;
  assign TRGG_START_CALC = r_trg;
  assign RX_RDY          = r_rx_rdy;
  assign BUSY            = r_busy;
  assign DBG_STATE       = r_state;

endmodule

// File: tb/tb_skeleton_bus_master.sv
// Bench for skeleton_bus_master: directed command sequences, a response /
// write-strobe model kept as expected queues, and a per-cycle compare
// process sampling on the falling clock edge.
module tb_skeleton_bus_master;

  localparam int SYS  = 16;
  localparam int AW   = 6;
  localparam int HW   = 26;
  localparam int TOUT = 15;

  // Clock / reset
  logic CLK_SYS = 1'b0;
  logic RSTN    = 1'b1;
  always #5 CLK_SYS = ~CLK_SYS;

  logic [7:0]     RX_DATA = '0;
  logic           RX_VALID = 1'b0;
  logic           RX_RDY;
  logic [7:0]     TX_DATA;
  logic           TX_VALID;
  logic           TX_RDY = 1'b1;
  logic           EN, RnW, TRGG_START_CALC, BUSY;
  logic [AW-1:0]  ADR;
  logic [SYS-1:0] DATA_IN;
  logic [SYS-1:0] DATA_OUT = '0;
  logic [HW-1:0]  DATA_HEAD = '0;
  logic           RDY = 1'b0;
  logic [2:0]     DBG_STATE;

  skeleton_bus_master #(
    .BITWIDTH_SYS(SYS), .BITWIDTH_ADR(AW), .BITWIDTH_HEAD(HW),
    .TRG_CYCLES(2), .TIMEOUT(TOUT)
  ) dut (
    .CLK_SYS(CLK_SYS), .RSTN(RSTN),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_RDY(RX_RDY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_RDY(TX_RDY),
    .EN(EN), .RnW(RnW), .ADR(ADR), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .DATA_HEAD(DATA_HEAD),
    .TRGG_START_CALC(TRGG_START_CALC), .RDY(RDY),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // Scoreboard
  logic [7:0]  exp_q[$];
  logic [21:0] exp_wr_q[$];   // {adr[5:0], data[15:0]}
  int n_cmp  = 0;
  int n_fail = 0;
  int n_tx   = 0;
  int n_wr   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected effect of one complete command.
  // aux = write data / read data / calc success flag / header value.
  task automatic model_cmd(input logic [7:0] cmd, input logic [31:0] aux);
    case (cmd[7:6])
      2'b00: exp_wr_q.push_back({cmd[5:0], aux[15:0]});
      2'b01: for (int i = 0; i < SYS / 8; i++)
               exp_q.push_back(8'((aux >> (8 * (SYS / 8 - 1 - i))) & 32'hFF));
      2'b10: exp_q.push_back(aux[0] ? 8'hA5 : 8'hEE);
      default: for (int i = 0; i < 4; i++)
                 exp_q.push_back(8'((aux >> (8 * (3 - i))) & 32'hFF));
    endcase
  endtask

  // Compare process
  int         since_rst  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] e_byte;
  logic [21:0] e_wr;

  always @(negedge CLK_SYS) begin
    if (!RSTN) begin
      since_rst  = 0;
      prev_stall = 1'b0;
    end else begin
      since_rst++;
      if (since_rst >= 2) check("en_high", EN, 1);
      check("rnw_trg_exclusive", {63'd0, (!RnW && TRGG_START_CALC)}, 0);
      if (prev_stall) begin
        check("tx_hold_valid", TX_VALID, 1);
        check("tx_hold_data", TX_DATA, prev_data);
      end
      if (TX_VALID && TX_RDY) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected: got %0h expected no byte", TX_DATA);
        end else begin
          e_byte = exp_q.pop_front();
          check("tx_byte", TX_DATA, e_byte);
        end
      end
      if (!RnW) begin
        n_wr++;
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wr_unexpected: got adr %0h data %0h expected no write", ADR, DATA_IN);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_strobe", {ADR, DATA_IN}, e_wr);
        end
      end
      prev_stall = TX_VALID && !TX_RDY;
      prev_data  = TX_DATA;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge CLK_SYS); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK_SYS);
    while (!RX_RDY && n < 100) begin
      n++;
      @(negedge CLK_SYS);
    end
    check("rx_accept_in_budget", RX_RDY, 1);
    @(posedge CLK_SYS); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge CLK_SYS);
    while ((BUSY || TX_VALID) && n < 200) begin
      n++;
      @(negedge CLK_SYS);
    end
    check(name, {62'd0, BUSY, TX_VALID}, 0);
    step();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    check("rst_en", EN, 0);
    check("rst_rnw", RnW, 1);
    check("rst_adr", ADR, 0);
    check("rst_data_in", DATA_IN, 0);
    check("rst_trg", TRGG_START_CALC, 0);
    check("rst_rx_rdy", RX_RDY, 0);
    check("rst_tx_valid", TX_VALID, 0);
    check("rst_tx_data", TX_DATA, 0);
    check("rst_busy", BUSY, 0);
    repeat (2) @(posedge CLK_SYS);
    #1 RSTN = 1'b1;
    @(negedge CLK_SYS);
    check("en_low_before_edge", EN, 0);
    @(negedge CLK_SYS);
    check("en_rise", EN, 1);
    check("rx_rdy_after_rst", RX_RDY, 1);
    step();
  endtask

  // Issues a CALC and measures trigger length and cycles spent waiting.
  task automatic run_calc(output int trg_len, output int wait_len);
    bit got = 0;
    trg_len  = 0;
    wait_len = 0;
    send_byte(8'h80);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK_SYS);
      if (TRGG_START_CALC) trg_len++;
      else if (TX_VALID) got = 1;
      else if (trg_len > 0) wait_len++;
    end
    check("calc_ack_in_budget", {63'd0, got}, 1);
  endtask

  int trg_len, wait_len;

  initial begin
    #2;
    do_reset();

    // WRITE 0x02, 0x12, 0x34
    model_cmd(8'h02, 32'h1234);
    send_byte(8'h02);
    send_byte(8'h12);
    check("busy_in_write", BUSY, 1);
    send_byte(8'h34);
    @(negedge CLK_SYS);
    check("wr_rnw_low", RnW, 0);
    check("wr_adr", ADR, 6'h02);
    check("wr_data", DATA_IN, 16'h1234);
    check("wr_rx_rdy_low", RX_RDY, 0);
    @(negedge CLK_SYS);
    check("wr_rnw_back", RnW, 1);
    check("wr_rx_rdy_back", RX_RDY, 1);
    check("wr_count", n_wr, 1);
    step();

    // READ 0x41, DATA_OUT = 0xBEEF, TX stalled 3 cycles
    DATA_OUT = 16'hBEEF;
    TX_RDY   = 1'b0;
    model_cmd(8'h41, 32'hBEEF);
    send_byte(8'h41);
    @(negedge CLK_SYS);
    check("rd_adr", ADR, 6'h01);
    check("rd_valid_n1", TX_VALID, 0);
    @(negedge CLK_SYS);
    check("rd_valid_n2", TX_VALID, 0);
    @(negedge CLK_SYS);
    check("rd_valid_n3", TX_VALID, 1);
    check("rd_first_byte", TX_DATA, 8'hBE);
    repeat (3) @(posedge CLK_SYS);
    #1 TX_RDY = 1'b1;
    wait_idle("rd_done");

    // CALC, RDY returns after 5 low cycles following the trigger
    model_cmd(8'h80, 1);
    fork
      run_calc(trg_len, wait_len);
      begin
        int n = 0;
        @(negedge CLK_SYS);
        while (!TRGG_START_CALC && n < 20) begin n++; @(negedge CLK_SYS); end
        while (TRGG_START_CALC && n < 40) begin n++; @(negedge CLK_SYS); end
        repeat (5) @(posedge CLK_SYS);
        #1 RDY = 1'b1;
      end
    join
    check("calc_trg_len", trg_len, 2);
    check("calc_wait_len", wait_len, 7);
    wait_idle("calc_done");
    RDY = 1'b0;

    // CALC with RDY already high: success without the extra cycle
    RDY = 1'b1;
    model_cmd(8'h80, 1);
    run_calc(trg_len, wait_len);
    check("calc_pre_trg_len", trg_len, 2);
    check("calc_pre_wait_len", wait_len, 1);
    wait_idle("calc_pre_done");
    RDY = 1'b0;

    // CALC timeout with RDY held low
    model_cmd(8'h80, 0);
    run_calc(trg_len, wait_len);
    check("calc_to_trg_len", trg_len, 2);
    check("calc_to_wait_len", wait_len, TOUT);
    wait_idle("calc_to_done");

    // HEAD 0xC0 after the timeout
    DATA_HEAD = 26'h0123456;
    model_cmd(8'hC0, 32'h00123456);
    send_byte(8'hC0);
    wait_idle("head_done");

    // READ at the top address
    DATA_OUT = 16'h00A1;
    model_cmd(8'h7F, 32'h00A1);
    send_byte(8'h7F);
    @(negedge CLK_SYS);
    check("rd2_adr", ADR, 6'h3F);
    wait_idle("rd2_done");

    // Reset in the middle of a WRITE, then a fresh WRITE
    send_byte(8'h05);
    send_byte(8'hAA);
    do_reset();
    model_cmd(8'h03, 32'h5678);
    send_byte(8'h03);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_idle("wr2_done");
    check("wr_total", n_wr, 2);

    // Reset while the trigger is high: it must drop without a clock
    send_byte(8'h80);
    check("trg_before_abort", TRGG_START_CALC, 1);
    RSTN = 1'b0;
    #1;
    check("trg_async_drop", TRGG_START_CALC, 0);
    do_reset();
    repeat (3) step();

    check("exp_tx_drained", exp_q.size(), 0);
    check("exp_wr_drained", exp_wr_q.size(), 0);
    check("tx_total", n_tx, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
